// File: rtl/clk_div_ctrl_pkg.sv
// Shared definitions for the clk_div_ctrl block: FSM state encodings and
// default parameter values used by the top and its phase counter.
package clk_div_ctrl_pkg;

    localparam int DIV_W_DFLT       = 8;
    localparam int DIV_DEFAULT_DFLT = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/clk_div_phase_cnt.sv
// Phase counter for clk_div_ctrl: counts 0..limit-1 and wraps, with a
// synchronous clear and a terminal-count flag (count == limit-1).
module clk_div_phase_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic         tc
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tc = (cnt_q == (limit - ONE));

    // Next count: clear wins, wrap at terminal count, otherwise increment.
    always_comb begin
        cnt_d = cnt_q + ONE;
        if (clr || tc) begin
            cnt_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Runtime-programmable clock divider controller. Produces a registered
// divided clock and sequences ratio changes and start/stop so they only take
// effect at the period boundary (the clkOut 1->0 edge).
// Optional build macro CLK_DIV_CTRL_TICK_EN adds the tickOut clock-enable
// pulse, high in the first clkIn cycle of every clkOut high phase.
module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int DIV_W       = DIV_W_DFLT,
    parameter int DIV_DEFAULT = DIV_DEFAULT_DFLT
) (
    input  logic             clkIn,
    input  logic             rstIn,
    input  logic             enIn,
    input  logic             reqIn,
    input  logic [DIV_W-1:0] divIn,
    output logic             ackOut,
    output logic             errOut,
    output logic             busyOut,
    output logic [DIV_W-1:0] divValOut,
    output logic             clkOut
`ifdef CLK_DIV_CTRL_TICK_EN
    ,
    output logic             tickOut
`endif
);

    state_e           state_q, state_d;
    logic             clk_q, clk_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             pend_q, pend_d;
    logic             ack_q, ack_d;
    logic             err_q, err_d;
    logic             tc;
    logic             running;
    logic             boundary;
    logic             req_valid;

    assign running   = (state_q != ST_IDLE);
    // The edge on which clkOut falls closes a full period.
    assign boundary  = running && tc && clk_q;
    // A request is not re-evaluated while its ack/err pulse is still visible.
    assign req_valid = reqIn && !ack_q && !err_q;

    clk_div_phase_cnt #(
        .W (DIV_W)
    ) u_phase_cnt (
        .clk   (clkIn),
        .rst   (rstIn),
        .clr   (state_q == ST_IDLE),
        .limit (div_q),
        .tc    (tc)
    );

    // Run/stop sequencing: stopping is only allowed on a period boundary.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enIn) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!enIn) state_d = boundary ? ST_IDLE : ST_DRAIN;
            end
            ST_DRAIN: begin
                if (enIn) state_d = ST_RUN;
                else if (boundary) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Divided clock, ratio register and request handshake.
    always_comb begin
        clk_d  = clk_q;
        div_d  = div_q;
        pend_d = pend_q;
        ack_d  = 1'b0;
        err_d  = 1'b0;

        if (running && tc) begin
            clk_d = ~clk_q;
        end

        if (req_valid && !pend_q) begin
            if (divIn == '0) begin
                err_d = 1'b1;
            end else if (state_q == ST_IDLE || divIn == div_q) begin
                div_d = divIn;
                ack_d = 1'b1;
            end else begin
                pend_d = 1'b1;
            end
        end

        // divIn is held stable by the requester, so it is sampled here.
        if (pend_q && boundary) begin
            div_d  = divIn;
            ack_d  = 1'b1;
            pend_d = 1'b0;
        end
    end

    // Control and output registers.
    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            state_q <= ST_IDLE;
            clk_q   <= 1'b0;
            div_q   <= DIV_W'(DIV_DEFAULT);
            pend_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            clk_q   <= clk_d;
            div_q   <= div_d;
            pend_q  <= pend_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

`ifdef CLK_DIV_CTRL_TICK_EN
    logic tick_q, tick_d;

    // Tick fires on the edge where clkOut rises.
    always_comb begin
        tick_d = running && tc && !clk_q;
    end

    // Tick register.
    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign tickOut = tick_q;
`endif

    assign clkOut    = clk_q;
    assign divValOut = div_q;
    assign ackOut    = ack_q;
    assign errOut    = err_q;
    assign busyOut   = running;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl (DIV_W=8, DIV_DEFAULT=4).
module tb_clk_div_ctrl;

    logic       clkIn;
    logic       rstIn;
    logic       enIn;
    logic       reqIn;
    logic [7:0] divIn;
    logic       ackOut;
    logic       errOut;
    logic       busyOut;
    logic [7:0] divValOut;
    logic       clkOut;
`ifdef CLK_DIV_CTRL_TICK_EN
    logic       tickOut;
`endif

    int checks = 0;
    int errors = 0;

    clk_div_ctrl #(
        .DIV_W       (8),
        .DIV_DEFAULT (4)
    ) dut (
        .clkIn     (clkIn),
        .rstIn     (rstIn),
        .enIn      (enIn),
        .reqIn     (reqIn),
        .divIn     (divIn),
        .ackOut    (ackOut),
        .errOut    (errOut),
        .busyOut   (busyOut),
        .divValOut (divValOut),
        .clkOut    (clkOut)
`ifdef CLK_DIV_CTRL_TICK_EN
        ,
        .tickOut   (tickOut)
`endif
    );

    initial clkIn = 1'b0;
    always #5 clkIn = ~clkIn;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clkIn);
            #1;
        end
    endtask

    initial begin
        rstIn = 1'b1;
        enIn  = 1'b0;
        reqIn = 1'b0;
        divIn = 8'd0;

        // Reset state
        #2;
        check("rst_clk", clkOut, 0);
        check("rst_ack", ackOut, 0);
        check("rst_err", errOut, 0);
        check("rst_busy", busyOut, 0);
        check("rst_div", divValOut, 4);
        step(2);
        rstIn = 1'b0;
        step(1);
        check("idle_busy", busyOut, 0);
        check("idle_clk", clkOut, 0);

        // Run at the default ratio: 4 low, 4 high
        enIn = 1'b1;
        step(1);
        check("run_busy", busyOut, 1);
        check("run_div", divValOut, 4);
        for (int r = 0; r < 8; r++) begin
            if (r > 0) step(1);
            check("wave4", clkOut, (r / 4) % 2);
        end

        // Ratio change to 2 requested mid-high phase: waits for the fall
        step(6);
        check("pre_req_clk", clkOut, 1);
        reqIn = 1'b1;
        divIn = 8'd2;
        step(1);
        check("pend_ack0", ackOut, 0);
        check("pend_div0", divValOut, 4);
        check("pend_clk0", clkOut, 1);
        step(1);
        check("pend_ack1", ackOut, 0);
        check("pend_div1", divValOut, 4);
        check("pend_clk1", clkOut, 1);
        step(1);
        check("chg_ack", ackOut, 1);
        check("chg_div", divValOut, 2);
        check("chg_clk", clkOut, 0);
        reqIn = 1'b0;
        for (int k = 1; k < 8; k++) begin
            step(1);
            check("wave2", clkOut, (k / 2) % 2);
            if (k == 1) check("chg_ack_drop", ackOut, 0);
        end

        // Zero ratio is rejected
        reqIn = 1'b1;
        divIn = 8'd0;
        step(1);
        check("err_pulse", errOut, 1);
        check("err_noack", ackOut, 0);
        check("err_div", divValOut, 2);
        reqIn = 1'b0;

        // Stop requested at a low phase: period completes, then idle
        enIn = 1'b0;
        step(1);
        check("err_drop", errOut, 0);
        check("drain_busy0", busyOut, 1);
        check("drain_clk0", clkOut, 0);
        step(1);
        check("drain_clk1", clkOut, 1);
        check("drain_busy1", busyOut, 1);
        step(1);
        check("drain_clk2", clkOut, 1);
        step(1);
        check("stop_clk", clkOut, 0);
        check("stop_busy", busyOut, 0);
        step(1);
        check("stop_clk_hold", clkOut, 0);
        check("stop_busy_hold", busyOut, 0);

        // Immediate accept while idle
        reqIn = 1'b1;
        divIn = 8'd7;
        step(1);
        check("idle_ack", ackOut, 1);
        check("idle_div", divValOut, 7);
        check("idle_acc_busy", busyOut, 0);
        reqIn = 1'b0;
        step(1);
        check("idle_ack_drop", ackOut, 0);

        // Run at 7; dip enIn during the low phase, waveform must not break
        enIn = 1'b1;
        step(1);
        for (int s = 0; s < 16; s++) begin
            if (s > 0) step(1);
            check("wave7", clkOut, (s / 7) % 2);
            check("wave7_busy", busyOut, 1);
            if (s == 2) enIn = 1'b0;
            if (s == 4) enIn = 1'b1;
        end

        // Pending change to 3 and stop meet at the same boundary
        reqIn = 1'b1;
        divIn = 8'd3;
        enIn  = 1'b0;
        step(12);
        check("both_pre_clk", clkOut, 1);
        check("both_pre_ack", ackOut, 0);
        check("both_pre_div", divValOut, 7);
        check("both_pre_busy", busyOut, 1);
        step(1);
        check("both_ack", ackOut, 1);
        check("both_div", divValOut, 3);
        check("both_busy", busyOut, 0);
        check("both_clk", clkOut, 0);
        reqIn = 1'b0;
        step(1);
        check("both_ack_drop", ackOut, 0);
        check("both_idle", busyOut, 0);

        // Reset asserted mid-high phase with a change pending
        enIn = 1'b1;
        step(1);
        step(3);
        check("r3_clk_high", clkOut, 1);
        reqIn = 1'b1;
        divIn = 8'd5;
        step(1);
        check("r3_clk_high2", clkOut, 1);
        #2;
        rstIn = 1'b1;
        #1;
        check("async_clk", clkOut, 0);
        check("async_busy", busyOut, 0);
        check("async_div", divValOut, 4);
        check("async_ack", ackOut, 0);
        reqIn = 1'b0;
        enIn  = 1'b0;
        @(negedge clkIn);
        rstIn = 1'b0;
        step(1);
        check("post_rst_ack", ackOut, 0);
        check("post_rst_div", divValOut, 4);
        step(2);
        check("post_rst_ack2", ackOut, 0);
        check("post_rst_clk", clkOut, 0);

        // Ratio 1: clkOut is clkIn/2
        reqIn = 1'b1;
        divIn = 8'd1;
        step(1);
        check("div1_ack", ackOut, 1);
        check("div1_div", divValOut, 1);
        reqIn = 1'b0;
        enIn  = 1'b1;
        step(1);
        check("div1_clk0", clkOut, 0);
`ifdef CLK_DIV_CTRL_TICK_EN
        check("div1_tick0", tickOut, 0);
`endif
        for (int k = 1; k < 9; k++) begin
            step(1);
            check("div1_wave", clkOut, k % 2);
`ifdef CLK_DIV_CTRL_TICK_EN
            check("div1_tick", tickOut, k % 2);
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
